regfile_pipe: RTL and testbench
===============================

REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register and data-path width in bits.
REQ-002 SHALL have parameter NREGS, default 16, meaning architectural register count (power of two, >=4).
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(NREGS), meaning register address width.
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have ports ra1, ra2, ra3  input  ADDR_WIDTH  meaning read addresses, ports 1-3.
REQ-008 SHALL have ports rv1, rv2, rv3  input  1  meaning read port actually used this cycle; qualifies stall.
REQ-009 SHALL have ports rd1, rd2, rd3  output  DATA_WIDTH  meaning combinational read data, ports 1-3.
REQ-010 SHALL have ports we3, wa3, wd3  input  1/ADDR_WIDTH/DATA_WIDTH  meaning ALU writeback enable, address, data.
REQ-011 SHALL have ports we4, wa4, wd4  input  1/ADDR_WIDTH/DATA_WIDTH  meaning load writeback enable, address, data.
REQ-012 SHALL have ports mark_en, mark_addr  input  1/ADDR_WIDTH  meaning load issued; destination becomes pending.
REQ-013 SHALL have port r15  input  DATA_WIDTH  meaning PC+8 value returned for reads of address NREGS-1.
REQ-014 SHALL have port stall  output  1  meaning a valid read targets a pending register.
REQ-015 SHALL have port pc_wr_err  output  1  meaning sticky flag: a write to address NREGS-1 was attempted.

Function
REQ-016 SHALL hold NREGS-1 storage registers (addresses 0..NREGS-2) plus NREGS pending bits; address NREGS-1 has no storage.
REQ-017 SHALL, on rising clk with weN=1 and waN<NREGS-1, write wdN into register waN; ignore enabled writes with waN=NREGS-1.
REQ-018 SHALL, when we3 and we4 both target the same address in one cycle, store wd3 (port 3 priority).
REQ-019 SHALL return r15 on any read port whose address is NREGS-1, regardless of writes or bypass.
REQ-020 SHALL, with BYPASS=1, return on rdN the write data of an enabled write to the same address (not NREGS-1) in the same cycle, port 3 over port 4; otherwise stored value.
REQ-021 SHALL, with BYPASS=0, make written data visible on rdN only after the writing clock edge (one-cycle latency).
REQ-022 SHALL set pending[mark_addr] on rising clk when mark_en=1 and mark_addr<NREGS-1; mark of NREGS-1 ignored.
REQ-023 SHALL clear pending[wa4] on rising clk when we4=1; we3 SHALL NOT clear pending bits.
REQ-024 SHALL, if mark and we4 clear hit the same address in one cycle, leave the bit set (mark wins).
REQ-025 SHALL drive stall = OR over N of (rvN and pending[raN]), combinationally; with BYPASS=1 a port whose raN equals wa4 with we4=1 SHALL NOT contribute.
REQ-026 SHALL set pc_wr_err on rising clk when we3 or we4 is enabled with address NREGS-1; cleared only by reset.
REQ-027 SHALL produce no X on rd1-rd3 for any in-range address after reset has been applied once.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force all storage registers to 0, all pending bits to 0, pc_wr_err to 0.
REQ-029 SHALL therefore drive stall=0 and rdN=0 (rdN=r15 for address NREGS-1) during and immediately after reset.
REQ-030 SHALL ignore we3, we4, mark_en on any edge where reset_n=0; reset asserted mid-write discards that write.

Verification
REQ-031 Reset then write R0=11110000, R1=22220000, R7=77770000, R14=EEEE0000 via port 3 -> ra1/ra2/ra3 = 0/1/7 read 11110000/22220000/77770000; ra1=14 reads EEEE0000.
REQ-032 r15=AAAA0000, we3=1 wa3=15 wd3=DEADDEAD -> all ports reading 15 return AAAA0000; pc_wr_err=1 after edge and stays 1.
REQ-033 BYPASS=1: we3=1 wa3=2 wd3=FFEEDDCC with ra1=2 before edge -> rd1=FFEEDDCC same cycle; BYPASS=0 -> rd1=0 until edge, then FFEEDDCC.
REQ-034 Same cycle we3 wa3=5 wd3=33333333 and we4 wa4=5 wd4=44444444 -> R5=33333333; pending[5] cleared.
REQ-035 mark_en addr=4; next cycle rv2=1 ra2=4 -> stall=1; rv2=0 -> stall=0; we4 wa4=4 wd4=12345678 -> stall=0 that cycle (BYPASS=1), rd2=12345678; mark+clear of 4 same edge -> stays pending.
REQ-036 Write R3=CAFEF00D, mark 3, assert reset_n=0 mid-cycle -> R3 reads 0, stall=0, pc_wr_err=0 without a clock edge.

Source files
------------

// File: rtl/regfile_pipe.sv
// Three-read, two-write register file with load-pending scoreboard and stall output.
// The top address holds no storage: reads return the r15 input and writes only raise pc_wr_err.
module regfile_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NREGS      = 16,
    parameter int ADDR_WIDTH = $clog2(NREGS),
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    input  logic [ADDR_WIDTH-1:0] ra3,
    input  logic                  rv1,
    input  logic                  rv2,
    input  logic                  rv3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] rd3,
    input  logic                  we3,
    input  logic [ADDR_WIDTH-1:0] wa3,
    input  logic [DATA_WIDTH-1:0] wd3,
    input  logic                  we4,
    input  logic [ADDR_WIDTH-1:0] wa4,
    input  logic [DATA_WIDTH-1:0] wd4,
    input  logic                  mark_en,
    input  logic [ADDR_WIDTH-1:0] mark_addr,
    input  logic [DATA_WIDTH-1:0] r15,
    output logic                  stall,
    output logic                  pc_wr_err
);

    localparam int                    NSTORE  = NREGS - 1;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(NREGS - 1);

    logic [DATA_WIDTH-1:0] regs_q [NSTORE];
    logic [DATA_WIDTH-1:0] regs_d [NSTORE];
    logic [NREGS-1:0]      pending_q, pending_d;
    logic                  pc_wr_err_q, pc_wr_err_d;
    logic                  wr3_ok, wr4_ok;
    logic [ADDR_WIDTH-1:0] ra_a [3];
    logic                  rv_a [3];
    logic [DATA_WIDTH-1:0] rd_a [3];

    always_comb begin
        wr3_ok    = we3 && (wa3 != PC_ADDR);
        wr4_ok    = we4 && (wa4 != PC_ADDR);
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int i = 0; i < NSTORE; i++) begin
            if (wr3_ok && wa3 == ADDR_WIDTH'(i)) begin
                regs_d[i] = wd3;
            end else if (wr4_ok && wa4 == ADDR_WIDTH'(i)) begin
                regs_d[i] = wd4;
            end
            // A new load issue outranks the older load's completion.
            if (mark_en && mark_addr == ADDR_WIDTH'(i)) begin
                pending_d[i] = 1'b1;
            end else if (we4 && wa4 == ADDR_WIDTH'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d[NREGS-1] = 1'b0;
        pc_wr_err_d = pc_wr_err_q | (we3 && wa3 == PC_ADDR) | (we4 && wa4 == PC_ADDR);
    end

    always_comb begin
        ra_a[0] = ra1;
        ra_a[1] = ra2;
        ra_a[2] = ra3;
        rv_a[0] = rv1;
        rv_a[1] = rv2;
        rv_a[2] = rv3;
        stall   = 1'b0;
        for (int p = 0; p < 3; p++) begin
            rd_a[p] = '0;
            if (ra_a[p] == PC_ADDR) begin
                rd_a[p] = r15;
            end else if (BYPASS != 0 && wr3_ok && wa3 == ra_a[p]) begin
                rd_a[p] = wd3;
            end else if (BYPASS != 0 && wr4_ok && wa4 == ra_a[p]) begin
                rd_a[p] = wd4;
            end else begin
                rd_a[p] = regs_q[ra_a[p]];
            end
            // With forwarding, the completing load's data is already on the read path.
            if (rv_a[p] && pending_q[ra_a[p]] &&
                !(BYPASS != 0 && we4 && wa4 == ra_a[p])) begin
                stall = 1'b1;
            end
        end
        rd1 = rd_a[0];
        rd2 = rd_a[1];
        rd3 = rd_a[2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q      <= '{default: '0};
            pending_q   <= '0;
            pc_wr_err_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pending_q   <= pending_d;
            pc_wr_err_q <= pc_wr_err_d;
        end
    end

    assign pc_wr_err = pc_wr_err_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Bench for regfile_pipe: a forwarding instance and a non-forwarding instance share all inputs
// and are compared against an array-based model of the register file and pending scoreboard.
module tb_regfile_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  ra [3];
    logic        rv [3];
    logic [31:0] rdb [3];
    logic [31:0] rdn [3];
    logic        we3, we4, mark_en;
    logic [3:0]  wa3, wa4, mark_addr;
    logic [31:0] wd3, wd4, r15;
    logic        stall_b, stall_n, err_b, err_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [16];
    bit          m_pend [16];
    bit          m_err;

    always #5 clk = ~clk;

    regfile_pipe #(.DATA_WIDTH(32), .NREGS(16), .BYPASS(1)) dut_byp (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra[0]), .ra2(ra[1]), .ra3(ra[2]),
        .rv1(rv[0]), .rv2(rv[1]), .rv3(rv[2]),
        .rd1(rdb[0]), .rd2(rdb[1]), .rd3(rdb[2]),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .r15(r15), .stall(stall_b), .pc_wr_err(err_b)
    );

    regfile_pipe #(.DATA_WIDTH(32), .NREGS(16), .BYPASS(0)) dut_nobyp (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra[0]), .ra2(ra[1]), .ra3(ra[2]),
        .rv1(rv[0]), .rv2(rv[1]), .rv3(rv[2]),
        .rd1(rdn[0]), .rd2(rdn[1]), .rd3(rdn[2]),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .r15(r15), .stall(stall_n), .pc_wr_err(err_n)
    );

    function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
        if (a == 4'd15) return r15;
        if (byp && we3 && wa3 == a) return wd3;
        if (byp && we4 && wa4 == a) return wd4;
        return m_regs[a];
    endfunction

    function automatic bit exp_stall(input bit byp);
        bit s = 1'b0;
        for (int p = 0; p < 3; p++)
            if (rv[p] && m_pend[ra[p]] && !(byp && we4 && wa4 == ra[p])) s = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic idle();
        we3 = 0; we4 = 0; mark_en = 0;
        wa3 = 0; wa4 = 0; mark_addr = 0; wd3 = 0; wd4 = 0;
        for (int p = 0; p < 3; p++) begin
            rv[p] = 0;
            ra[p] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (we4 && wa4 != 4'd15) m_regs[wa4] = wd4;
            if (we3 && wa3 != 4'd15) m_regs[wa3] = wd3;
            if (we4) m_pend[wa4] = 1'b0;
            if (mark_en && mark_addr != 4'd15) m_pend[mark_addr] = 1'b1;
            if ((we3 && wa3 == 4'd15) || (we4 && wa4 == 4'd15)) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        r15 = 32'h0BAD_F00D;
        ra[0] = 0; ra[1] = 5; ra[2] = 15;
        for (int p = 0; p < 3; p++) rv[p] = 1;
        model_reset();
        #2;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (rdb[p] !== (p == 2 ? 32'h0BAD_F00D : 32'h0) || rdn[p] !== (p == 2 ? 32'h0BAD_F00D : 32'h0)) begin
                failures++;
                $display("FAIL reset_rd port%0d: byp=%h nobyp=%h", p + 1, rdb[p], rdn[p]);
            end
        end
        checks++;
        if (stall_b !== 0 || stall_n !== 0 || err_b !== 0 || err_n !== 0) begin
            failures++;
            $display("FAIL reset_flags: stall=%b/%b err=%b/%b exp 0", stall_b, stall_n, err_b, err_n);
        end
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++;
        if (stall_b !== 0 || rdb[0] !== 0 || rdn[1] !== 0) begin
            failures++;
            $display("FAIL post_reset: stall=%b rd1=%h rd2=%h exp 0", stall_b, rdb[0], rdn[1]);
        end
        tick();
    endtask

    task automatic test_regs_write();
        logic [3:0]  addrs [4] = '{4'd0, 4'd1, 4'd7, 4'd14};
        logic [31:0] vals  [4] = '{32'h1111_0000, 32'h2222_0000, 32'h7777_0000, 32'hEEEE_0000};
        idle();
        for (int i = 0; i < 4; i++) begin
            we3 = 1; wa3 = addrs[i]; wd3 = vals[i];
            tick();
        end
        idle();
        ra[0] = 0; ra[1] = 1; ra[2] = 7;
        #2;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (rdb[p] !== vals[p] || rdn[p] !== vals[p]) begin
                failures++;
                $display("FAIL regs_read port%0d: byp=%h nobyp=%h exp %h", p + 1, rdb[p], rdn[p], vals[p]);
            end
        end
        ra[0] = 14;
        #2;
        checks++;
        if (rdb[0] !== 32'hEEEE_0000 || rdn[0] !== 32'hEEEE_0000) begin
            failures++;
            $display("FAIL regs_read_r14: byp=%h nobyp=%h exp eeee0000", rdb[0], rdn[0]);
        end
        tick();
    endtask

    task automatic test_pc_write();
        idle();
        r15 = 32'hAAAA_0000;
        we3 = 1; wa3 = 15; wd3 = 32'hDEAD_DEAD;
        for (int p = 0; p < 3; p++) ra[p] = 15;
        #2;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (rdb[p] !== 32'hAAAA_0000 || rdn[p] !== 32'hAAAA_0000) begin
                failures++;
                $display("FAIL pc_read port%0d: byp=%h nobyp=%h exp aaaa0000", p + 1, rdb[p], rdn[p]);
            end
        end
        checks++;
        if (err_b !== 0) begin
            failures++;
            $display("FAIL pc_err_before_edge: got %b exp 0", err_b);
        end
        tick();
        we3 = 0;
        #2;
        checks++;
        if (err_b !== 1 || err_n !== 1 || rdb[1] !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL pc_err_set: err=%b/%b rd2=%h exp 1/1/aaaa0000", err_b, err_n, rdb[1]);
        end
        repeat (3) tick();
        checks++;
        if (err_b !== 1 || err_n !== 1) begin
            failures++;
            $display("FAIL pc_err_sticky: err=%b/%b exp 1", err_b, err_n);
        end
    endtask

    task automatic test_bypass();
        idle();
        ra[0] = 2;
        we3 = 1; wa3 = 2; wd3 = 32'hFFEE_DDCC;
        #2;
        checks++;
        if (rdb[0] !== 32'hFFEE_DDCC || rdn[0] !== 32'h0) begin
            failures++;
            $display("FAIL bypass_same_cycle: byp=%h exp ffeeddcc nobyp=%h exp 0", rdb[0], rdn[0]);
        end
        tick();
        we3 = 0;
        #2;
        checks++;
        if (rdb[0] !== 32'hFFEE_DDCC || rdn[0] !== 32'hFFEE_DDCC) begin
            failures++;
            $display("FAIL bypass_after_edge: byp=%h nobyp=%h exp ffeeddcc", rdb[0], rdn[0]);
        end
    endtask

    task automatic test_dual_write();
        idle();
        mark_en = 1; mark_addr = 5;
        tick();
        mark_en = 0;
        we3 = 1; wa3 = 5; wd3 = 32'h3333_3333;
        we4 = 1; wa4 = 5; wd4 = 32'h4444_4444;
        ra[0] = 5; rv[0] = 1;
        #2;
        checks++;
        if (rdb[0] !== 32'h3333_3333 || stall_b !== 0 || stall_n !== 1) begin
            failures++;
            $display("FAIL dual_same_cycle: rd1=%h stall=%b/%b exp 33333333 0/1", rdb[0], stall_b, stall_n);
        end
        tick();
        we3 = 0; we4 = 0;
        #2;
        checks++;
        if (rdb[0] !== 32'h3333_3333 || rdn[0] !== 32'h3333_3333 || stall_b !== 0 || stall_n !== 0) begin
            failures++;
            $display("FAIL dual_result: rd1=%h/%h stall=%b/%b exp 33333333 0", rdb[0], rdn[0], stall_b, stall_n);
        end
        tick();
    endtask

    task automatic test_pending();
        idle();
        mark_en = 1; mark_addr = 4;
        tick();
        mark_en = 0;
        rv[1] = 1; ra[1] = 4;
        #2;
        checks++;
        if (stall_b !== 1 || stall_n !== 1) begin
            failures++;
            $display("FAIL pend_stall: got %b/%b exp 1", stall_b, stall_n);
        end
        rv[1] = 0;
        #2;
        checks++;
        if (stall_b !== 0 || stall_n !== 0) begin
            failures++;
            $display("FAIL pend_unused_port: got %b/%b exp 0", stall_b, stall_n);
        end
        rv[1] = 1;
        we4 = 1; wa4 = 4; wd4 = 32'h1234_5678;
        #2;
        checks++;
        if (stall_b !== 0 || rdb[1] !== 32'h1234_5678 || stall_n !== 1 || rdn[1] !== 32'h0) begin
            failures++;
            $display("FAIL pend_load_return: byp stall=%b rd2=%h nobyp stall=%b rd2=%h exp 0/12345678 1/0",
                     stall_b, rdb[1], stall_n, rdn[1]);
        end
        tick();
        we4 = 0;
        #2;
        checks++;
        if (stall_b !== 0 || stall_n !== 0 || rdn[1] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL pend_cleared: stall=%b/%b rd2=%h exp 0/0/12345678", stall_b, stall_n, rdn[1]);
        end
        mark_en = 1; mark_addr = 4;
        we4 = 1; wa4 = 4; wd4 = 32'h0000_0055;
        tick();
        mark_en = 0; we4 = 0;
        #2;
        checks++;
        if (stall_b !== 1 || stall_n !== 1 || rdb[1] !== 32'h0000_0055) begin
            failures++;
            $display("FAIL pend_mark_wins: stall=%b/%b rd2=%h exp 1/1/00000055", stall_b, stall_n, rdb[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we3 = ($urandom_range(0, 2) == 0);
            wa3 = 4'($urandom_range(0, 15));
            wd3 = $urandom;
            we4 = ($urandom_range(0, 2) == 0);
            wa4 = ($urandom_range(0, 1) == 0) ? ra[$urandom_range(0, 2)] : 4'($urandom_range(0, 15));
            wd4 = $urandom;
            mark_en = ($urandom_range(0, 3) == 0);
            mark_addr = 4'($urandom_range(0, 15));
            r15 = $urandom;
            for (int p = 0; p < 3; p++) begin
                ra[p] = 4'($urandom_range(0, 15));
                rv[p] = $urandom_range(0, 1) == 1;
            end
            #2;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (rdb[p] !== exp_rd(ra[p], 1'b1) || rdn[p] !== exp_rd(ra[p], 1'b0)) begin
                    failures++;
                    $display("FAIL rand_rd c%0d port%0d a=%0d: byp=%h exp %h nobyp=%h exp %h", c, p + 1, ra[p],
                             rdb[p], exp_rd(ra[p], 1'b1), rdn[p], exp_rd(ra[p], 1'b0));
                end
            end
            checks++;
            if (stall_b !== exp_stall(1'b1) || stall_n !== exp_stall(1'b0) || err_b !== m_err || err_n !== m_err) begin
                failures++;
                $display("FAIL rand_flags c%0d: stall=%b/%b exp %b/%b err=%b/%b exp %b", c, stall_b, stall_n,
                         exp_stall(1'b1), exp_stall(1'b0), err_b, err_n, m_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        we3 = 1; wa3 = 3; wd3 = 32'hCAFE_F00D;
        tick();
        we3 = 0;
        mark_en = 1; mark_addr = 3;
        tick();
        mark_en = 0;
        rv[0] = 1; ra[0] = 3;
        #2;
        checks++;
        if (rdb[0] !== 32'hCAFE_F00D || stall_b !== 1 || err_b !== 1) begin
            failures++;
            $display("FAIL midrst_setup: rd1=%h stall=%b err=%b exp cafef00d 1 1", rdb[0], stall_b, err_b);
        end
        we3 = 1; wa3 = 3; wd3 = 32'h1111_1111;
        #1;
        reset_n = 0;
        model_reset();
        #1;
        we3 = 0;
        #1;
        checks++;
        if (rdb[0] !== 0 || rdn[0] !== 0 || stall_b !== 0 || stall_n !== 0 || err_b !== 0 || err_n !== 0) begin
            failures++;
            $display("FAIL midrst_async: rd1=%h/%h stall=%b/%b err=%b/%b exp 0", rdb[0], rdn[0],
                     stall_b, stall_n, err_b, err_n);
        end
        we3 = 1; wd3 = 32'h2222_2222;
        mark_en = 1; mark_addr = 3;
        tick();
        we3 = 0; mark_en = 0;
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++;
        if (rdb[0] !== 0 || rdn[0] !== 0 || stall_b !== 0 || err_b !== 0) begin
            failures++;
            $display("FAIL midrst_held: rd1=%h/%h stall=%b err=%b exp 0", rdb[0], rdn[0], stall_b, err_b);
        end
    endtask

    initial begin
        test_reset();
        test_regs_write();
        test_pc_write();
        test_bypass();
        test_dual_write();
        test_pending();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
